// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR with Fibonacci/Galois forms, run-time seed
// load, all-zero lock-up recovery and measurement of the sequence period.
// The period is the number of steps taken to return to the reference
// state, which is the last loaded seed, the recovery seed, or the first
// state reached after a change of mode.

module lfsr_gen #(
   parameter int              WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS = 16'hB400,
   parameter logic [WIDTH-1:0] SEED = 16'h01AB
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             mode,
   output logic [WIDTH-1:0] state_out,
   output logic             bit_out,
   output logic             lockup,
   output logic [WIDTH-1:0] period,
   output logic             period_done
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] ref_q;
   logic [WIDTH-1:0] step_cnt;
   logic             mode_q;

   logic             fib_fb;
   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;
   logic [WIDTH-1:0] next_state;

   // Next state in both forms; the requested mode picks one, so a step taken
   // right after a mode change already uses the new form.
   always_comb begin
      fib_fb     = ^(state_q & TAPS);
      fib_next   = {state_q[WIDTH-2:0], fib_fb};
      gal_next   = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
      next_state = mode ? gal_next : fib_next;
   end

   // Register update: reset, then load, then enable (recovery, re-reference
   // on mode change, or a normal step with period detection), else hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= SEED;
         ref_q       <= SEED;
         step_cnt    <= '0;
         period      <= '0;
         period_done <= 1'b0;
         mode_q      <= 1'b0;
      end else if (load) begin
         state_q     <= seed_in;
         ref_q       <= seed_in;
         step_cnt    <= '0;
         mode_q      <= mode;
         period_done <= 1'b0;
      end else if (enable) begin
         if (state_q == '0) begin
            state_q     <= SEED;
            ref_q       <= SEED;
            step_cnt    <= '0;
            period_done <= 1'b0;
         end else if (mode != mode_q) begin
            state_q     <= next_state;
            ref_q       <= next_state;
            step_cnt    <= '0;
            mode_q      <= mode;
            period_done <= 1'b0;
         end else begin
            state_q <= next_state;
            if (next_state == ref_q) begin
               period      <= step_cnt + 1'b1;
               step_cnt    <= '0;
               period_done <= 1'b1;
            end else begin
               step_cnt    <= step_cnt + 1'b1;
               period_done <= 1'b0;
            end
         end
      end else begin
         period_done <= 1'b0;
      end
   end

   // Serial bit and lock-up flag follow the current state combinationally.
   always_comb begin
      state_out = state_q;
      bit_out   = mode ? state_q[0] : state_q[WIDTH-1];
      lockup    = (state_q == '0);
   end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: self-checking bench for lfsr_gen. A 16-bit default instance
// is driven by directed and random stimulus and compared every cycle with a
// reference model that tracks the trail of states visited since the current
// reference point. A second 4-bit instance checks full-period behaviour in
// both forms.

module tb_lfsr_gen;

   localparam int W    = 16;
   localparam int TAPS = 'hB400;
   localparam int SEED = 'h01AB;
   localparam int MASK = 'hFFFF;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        load;
   logic [15:0] seed_in;
   logic        mode;
   logic [15:0] state_out;
   logic        bit_out;
   logic        lockup;
   logic [15:0] period;
   logic        period_done;

   logic        reset_s;
   logic        enable_s;
   logic        load_s;
   logic [3:0]  seed_s;
   logic        mode_s;
   logic [3:0]  state_s;
   logic        bit_s;
   logic        lockup_s;
   logic [3:0]  period_s;
   logic        done_s;

   int assertCount;
   int failCount;

   int  mState;
   int  mPeriod;
   bit  mModeQ;
   bit  mDone;
   int  trail[$];

   lfsr_gen dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .seed_in(seed_in), .mode(mode), .state_out(state_out),
      .bit_out(bit_out), .lockup(lockup), .period(period),
      .period_done(period_done)
   );

   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dutSmall (
      .clk(clk), .reset(reset_s), .enable(enable_s), .load(load_s),
      .seed_in(seed_s), .mode(mode_s), .state_out(state_s),
      .bit_out(bit_s), .lockup(lockup_s), .period(period_s),
      .period_done(done_s)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One LFSR step computed arithmetically from the polynomial rules.
   function automatic int stepModel(input int s, input bit md, input int w, input int taps);
      int msk;
      msk = (1 << w) - 1;
      if (!md)
         return ((s << 1) & msk) | ($countones(s & taps) & 1);
      else
         return (s >> 1) ^ (((s & 1) != 0) ? taps : 0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour: the period is the length of the trail of states
   // seen since the reference, measured when a step lands back on its head.
   task automatic modelClock(input bit rst, input bit en, input bit ld, input int sd, input bit md);
      int nx;
      if (!rst) begin
         mState = SEED; trail = '{SEED}; mPeriod = 0; mDone = 0; mModeQ = 0;
      end else if (ld) begin
         mState = sd & MASK; trail = '{sd & MASK}; mModeQ = md; mDone = 0;
      end else if (en) begin
         if (mState == 0) begin
            mState = SEED; trail = '{SEED}; mDone = 0;
         end else begin
            nx = stepModel(mState, md, W, TAPS);
            mState = nx;
            if (md != mModeQ) begin
               trail = '{nx}; mModeQ = md; mDone = 0;
            end else if (nx == trail[0]) begin
               mPeriod = trail.size() & MASK; trail = '{nx}; mDone = 1;
            end else begin
               trail.push_back(nx); mDone = 0;
            end
         end
      end else begin
         mDone = 0;
      end
   endtask

   // Drive one cycle of inputs, advance the model and compare all outputs.
   task automatic applyStimulus(input bit rst, input bit en, input bit ld, input int sd, input bit md);
      reset = rst; enable = en; load = ld; seed_in = sd[15:0]; mode = md;
      @(posedge clk);
      #1;
      modelClock(rst, en, ld, sd, md);
      checkOutput("state", {16'h0, state_out}, mState);
      checkOutput("lockup", {31'h0, lockup}, {31'h0, mState == 0});
      checkOutput("bitOut", {31'h0, bit_out}, md ? (mState & 1) : ((mState >> 15) & 1));
      checkOutput("period", {16'h0, period}, mPeriod);
      checkOutput("periodDone", {31'h0, period_done}, {31'h0, mDone});
   endtask

   initial begin
      bit md;
      bit ld;
      bit en;
      bit rst;
      int sd;
      int expS;
      int seen;
      bit visited [16];

      assertCount = 0;
      failCount   = 0;
      mState = SEED; trail = '{SEED}; mPeriod = 0; mDone = 0; mModeQ = 0;
      reset = 1'b0; enable = 1'b0; load = 1'b0; seed_in = '0; mode = 1'b0;
      reset_s = 1'b0; enable_s = 1'b0; load_s = 1'b0; seed_s = '0; mode_s = 1'b0;

      // Reset state.
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      reset_s = 1'b1;
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("resetState", {16'h0, state_out}, 32'h01AB);
      checkOutput("resetPeriod", {16'h0, period}, 32'h0);
      checkOutput("resetLockup", {31'h0, lockup}, 32'h0);
      checkOutput("resetDone", {31'h0, period_done}, 32'h0);

      // Single step in each form.
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("fibStep", {16'h0, state_out}, 32'h0356);
      checkOutput("fibBit", {31'h0, bit_out}, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 1, 0, 0, 1);
      checkOutput("galStep", {16'h0, state_out}, 32'hB4D5);
      checkOutput("galBit", {31'h0, bit_out}, 32'h1);

      // Lock-up and recovery.
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("lockupHigh", {31'h0, lockup}, 32'h1);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("lockupHold", {16'h0, state_out}, 32'h0);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("recoverState", {16'h0, state_out}, 32'h01AB);
      checkOutput("recoverLockup", {31'h0, lockup}, 32'h0);

      // Load wins over enable.
      applyStimulus(1, 1, 1, 'h1234, 0);
      checkOutput("loadPriority", {16'h0, state_out}, 32'h1234);

      // Mode toggled mid-run, including while idle.
      for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0, 0, 1);

      // Full Fibonacci period at default width.
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 65535; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         checkOutput("fullDone", {31'h0, period_done}, {31'h0, i == 65534});
         checkOutput("noEarlyRepeat", {31'h0, state_out == 16'h01AB}, {31'h0, i == 65534});
      end
      checkOutput("fullPeriod", {16'h0, period}, 32'hFFFF);
      checkOutput("fullState", {16'h0, state_out}, 32'h01AB);

      // Reset mid-run clears the measured period.
      for (int i = 0; i < 100; i++) applyStimulus(1, 1, 0, 0, 0);
      checkOutput("periodKept", {16'h0, period}, 32'hFFFF);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("midResetState", {16'h0, state_out}, 32'h01AB);
      checkOutput("midResetPeriod", {16'h0, period}, 32'h0);

      // Random traffic against the model.
      md = 0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         ld  = ($urandom_range(0, 49) == 0);
         en  = ($urandom_range(0, 9) < 7);
         sd  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom & 32'hFFFF);
         if ($urandom_range(0, 99) == 0) md = ~md;
         applyStimulus(rst, en, ld, sd, md);
      end

      // Full period at 4 bits in both forms.
      for (int m = 0; m < 2; m++) begin
         load_s = 1'b1; seed_s = 4'h1; mode_s = m[0]; enable_s = 1'b0;
         @(posedge clk);
         #1;
         load_s = 1'b0; enable_s = 1'b1;
         expS = 1;
         for (int v = 0; v < 16; v++) visited[v] = 0;
         for (int s = 1; s <= 45; s++) begin
            @(posedge clk);
            #1;
            expS = stepModel(expS, m[0], 4, 'hC);
            checkOutput("smallState", {28'h0, state_s}, expS);
            visited[state_s] = 1;
            if (s % 15 == 0) begin
               seen = 0;
               for (int v = 1; v < 16; v++) seen += visited[v] ? 1 : 0;
               checkOutput("smallDone", {31'h0, done_s}, 32'h1);
               checkOutput("smallPeriod", {28'h0, period_s}, 32'd15);
               checkOutput("smallVisited", seen, 32'd15);
            end else begin
               checkOutput("smallDone", {31'h0, done_s}, 32'h0);
            end
         end
         enable_s = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
